// File: rtl/lname_mbus_pkg.sv
// Shared definitions for the MBus member power/interrupt controller.
package lname_mbus_pkg;

  // Power-gating FSM states; the encoding is exported on PG_STATE for debug.
  typedef enum logic [2:0] {
    ST_SLEEP    = 3'd0,
    ST_WAKE_PWR = 3'd1,
    ST_WAKE_RST = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_GO_ISO   = 3'd4,
    ST_GO_RST   = 3'd5
  } pg_state_e;

  // Legal configuration ranges.
  localparam int unsigned NUM_WAKE_MIN = 1;
  localparam int unsigned NUM_WAKE_MAX = 8;
  localparam int unsigned ADDR_W_MIN   = 4;
  localparam int unsigned ADDR_W_MAX   = 8;
  localparam int unsigned DLY_MIN      = 1;
  localparam int unsigned DLY_MAX      = 15;

  // Width of the wake-sequence delay counter.
  localparam int unsigned DLY_CNT_W    = 4;

endpackage

// File: rtl/lname_mbus_int_chan.sv
// One wakeup/interrupt channel: rising-edge detect on the request level and
// the pending flop that drives EXTERNAL_INT.
module lname_mbus_int_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic wakeup_req,
  input  logic clr_req,
  input  logic set_en,
  input  logic clr_en,
  output logic pending,
  output logic pend_rise
);

  logic req_prev_q, req_prev_d;
  logic pend_q, pend_d;
  logic set_w;

  // Edge detect and pending update; a set in the same cycle as a clear wins.
  always_comb begin
    req_prev_d = wakeup_req;
    set_w      = set_en & wakeup_req & ~req_prev_q;
    pend_d     = pend_q;
    if (clr_req && clr_en) pend_d = 1'b0;
    if (set_w)             pend_d = 1'b1;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      req_prev_q <= req_prev_d;
      pend_q     <= pend_d;
    end
  end

  assign pending   = pend_q;
  assign pend_rise = set_w & ~pend_q;

endmodule

// File: rtl/lname_mbus_member_ctrl_gen.sv
// MBus member controller: power-gating sequencer, per-channel interrupt
// pending/bus-request logic and the short-prefix address register.
module lname_mbus_member_ctrl_gen
  import lname_mbus_pkg::*;
#(
  parameter int unsigned NUM_WAKE = 1,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PWR_DLY  = 2,
  parameter int unsigned ISO_DLY  = 1
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                SLEEP_REQ,
  input  logic                BUS_WAKE,
  input  logic [NUM_WAKE-1:0] WAKEUP_REQ,
  input  logic [NUM_WAKE-1:0] CLR_EXT_INT,
  input  logic                MBUS_BUSY,
  input  logic                LRC_SLEEP,
  input  logic                BUS_GRANT,
  input  logic                ADDR_WR_EN,
  input  logic                ADDR_CLR_B,
  input  logic [ADDR_W-1:0]   ADDR_IN,
  output logic                MBC_SLEEP,
  output logic                MBC_SLEEP_B,
  output logic                MBC_ISOLATE,
  output logic                MBC_ISOLATE_B,
  output logic                MBC_RESET,
  output logic                MBC_RESET_B,
  output logic [NUM_WAKE-1:0] EXTERNAL_INT,
  output logic                INT_BUS_REQ,
  output logic [ADDR_W-1:0]   ADDR_OUT,
  output logic                ADDR_VALID,
  output logic [2:0]          PG_STATE
);

  if (NUM_WAKE < NUM_WAKE_MIN || NUM_WAKE > NUM_WAKE_MAX ||
      ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX ||
      PWR_DLY < DLY_MIN || PWR_DLY > DLY_MAX ||
      ISO_DLY < DLY_MIN || ISO_DLY > DLY_MAX) begin : g_cfg_err
    $error("lname_mbus_member_ctrl_gen: parameter out of legal range");
  end

  // The counter is loaded with DLY-1 on entry and the exit fires when it
  // reads zero, so each wake phase lasts exactly DLY cycles.
  localparam logic [DLY_CNT_W-1:0] PWR_LOAD = DLY_CNT_W'(PWR_DLY - 1);
  localparam logic [DLY_CNT_W-1:0] ISO_LOAD = DLY_CNT_W'(ISO_DLY - 1);

  pg_state_e              state_q, state_d;
  logic [DLY_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   sleep_q, sleep_d;
  logic                   iso_q, iso_d;
  logic                   rst_q, rst_d;
  logic                   ibr_q, ibr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   av_q, av_d;

  logic [NUM_WAKE-1:0]    pend;
  logic [NUM_WAKE-1:0]    pend_rise;
  logic                   set_en;
  logic                   clr_en;

  assign set_en = LRC_SLEEP & ~(MBUS_BUSY & (state_q == ST_ACTIVE));
  assign clr_en = ~iso_q;

  for (genvar g = 0; g < NUM_WAKE; g++) begin : g_chan
    lname_mbus_int_chan u_chan (
      .clk        (CLK),
      .rst_n      (RESETn),
      .wakeup_req (WAKEUP_REQ[g]),
      .clr_req    (CLR_EXT_INT[g]),
      .set_en     (set_en),
      .clr_en     (clr_en),
      .pending    (pend[g]),
      .pend_rise  (pend_rise[g])
    );
  end

  // Next state and delay counter; control outputs decoded from the next state
  // so they are registered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SLEEP: begin
        if (BUS_WAKE || (|pend)) begin
          state_d = ST_WAKE_PWR;
          cnt_d   = PWR_LOAD;
        end
      end
      ST_WAKE_PWR: begin
        if (cnt_q == '0) begin
          state_d = ST_WAKE_RST;
          cnt_d   = ISO_LOAD;
        end else begin
          cnt_d = cnt_q - DLY_CNT_W'(1);
        end
      end
      ST_WAKE_RST: begin
        if (cnt_q == '0) state_d = ST_ACTIVE;
        else             cnt_d   = cnt_q - DLY_CNT_W'(1);
      end
      ST_ACTIVE: begin
        if (SLEEP_REQ && !MBUS_BUSY) state_d = ST_GO_ISO;
      end
      ST_GO_ISO: state_d = ST_GO_RST;
      ST_GO_RST: state_d = ST_SLEEP;
      default:   state_d = ST_SLEEP;
    endcase
    sleep_d = (state_d == ST_SLEEP);
    iso_d   = (state_d != ST_ACTIVE);
    rst_d   = (state_d == ST_SLEEP) || (state_d == ST_WAKE_PWR) ||
              (state_d == ST_GO_RST);
  end

  // Power-gating FSM registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_SLEEP;
      cnt_q   <= '0;
      sleep_q <= 1'b1;
      iso_q   <= 1'b1;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sleep_q <= sleep_d;
      iso_q   <= iso_d;
      rst_q   <= rst_d;
    end
  end

  // Bus request and address register; address inputs are ignored while isolated.
  always_comb begin
    ibr_d  = (|pend_rise) | (ibr_q & ~BUS_GRANT);
    addr_d = addr_q;
    av_d   = av_q;
    if (!iso_q) begin
      if (!ADDR_CLR_B) begin
        addr_d = '1;
        av_d   = 1'b0;
      end else if (ADDR_WR_EN) begin
        addr_d = ADDR_IN;
        av_d   = 1'b1;
      end
    end
  end

  // Interrupt request and address registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ibr_q  <= 1'b0;
      addr_q <= '1;
      av_q   <= 1'b0;
    end else begin
      ibr_q  <= ibr_d;
      addr_q <= addr_d;
      av_q   <= av_d;
    end
  end

  assign MBC_SLEEP     = sleep_q;
  assign MBC_SLEEP_B   = ~sleep_q;
  assign MBC_ISOLATE   = iso_q;
  assign MBC_ISOLATE_B = ~iso_q;
  assign MBC_RESET     = rst_q;
  assign MBC_RESET_B   = ~rst_q;
  assign EXTERNAL_INT  = pend;
  assign INT_BUS_REQ   = ibr_q;
  assign ADDR_OUT      = addr_q;
  assign ADDR_VALID    = av_q;
  assign PG_STATE      = state_q;

endmodule
